ram_block_copier: RTL and testbench



---
 rtl/ram_block_copier.sv | 178 +++++++++++++++++
 tb/tb_ram_block_copier.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ram_block_copier.sv
// Word-granular RAM block copier: alternates a read and a write-back per word (2 cycles/word).
// Optional macro COPY_FILL_EN adds a pattern-fill mode that writes one word per cycle.
module ram_block_copier #(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [ADDR_WIDTH-1:0] start_src,
  input  logic [ADDR_WIDTH-1:0] start_dst,
  input  logic [LEN_WIDTH-1:0]  start_len,
`ifdef COPY_FILL_EN
  input  logic                  start_fill,
  input  logic [31:0]           start_pattern,
`endif
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_wren,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    FILL = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO   = LEN_WIDTH'(0);

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [31:0]           pattern;

  // Control FSM: pointers, counters and the status outputs are all registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      remaining   <= '0;
      words_done  <= '0;
      pattern     <= 32'h0000_0000;
      done        <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_valid) begin
            src_ptr     <= start_src & ALIGN_MASK;
            dst_ptr     <= start_dst & ALIGN_MASK;
            remaining   <= start_len;
            words_done  <= '0;
            busy        <= 1'b1;
            start_ready <= 1'b0;
`ifdef COPY_FILL_EN
            pattern <= start_pattern;
            if (start_len == LEN_ZERO) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (start_fill) begin
              state <= FILL;
            end else begin
              state <= RD;
            end
`else
            if (start_len == LEN_ZERO) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RD;
            end
`endif
          end
        end
        RD: begin
          state <= WR;
        end
        WR: begin
          src_ptr    <= src_ptr + WORD_STEP;
          dst_ptr    <= dst_ptr + WORD_STEP;
          remaining  <= remaining - LEN_ONE;
          words_done <= words_done + LEN_ONE;
          if (remaining == LEN_ONE) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RD;
          end
        end
`ifdef COPY_FILL_EN
        FILL: begin
          dst_ptr    <= dst_ptr + WORD_STEP;
          remaining  <= remaining - LEN_ONE;
          words_done <= words_done + LEN_ONE;
          if (remaining == LEN_ONE) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
`endif
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

  // RAM request decode; write data is the previous cycle's read data passed straight through.
  always_comb begin
    mem_cs    = 1'b0;
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0000_0000;
    mem_wmask = 4'h0;
    if (reset) begin
      mem_cs    = 1'b0;
      mem_wren  = 1'b0;
    end else begin
      case (state)
        RD: begin
          mem_cs   = 1'b1;
          mem_addr = src_ptr;
        end
        WR: begin
          mem_cs    = 1'b1;
          mem_wren  = 1'b1;
          mem_wmask = 4'hF;
          mem_addr  = dst_ptr;
          mem_wdata = mem_rdata;
        end
`ifdef COPY_FILL_EN
        FILL: begin
          mem_cs    = 1'b1;
          mem_wren  = 1'b1;
          mem_wmask = 4'hF;
          mem_addr  = dst_ptr;
          mem_wdata = pattern;
        end
`endif
        default: begin
          mem_cs = 1'b0;
        end
      endcase
    end
  end

`ifndef COPY_FILL_EN
  // Without fill mode the pattern register is never loaded; keep it referenced.
  logic unused_pattern;
  assign unused_pattern = ^pattern;
`endif

endmodule

// File: tb/tb_ram_block_copier.sv
// Directed bench for ram_block_copier with a 1-cycle-latency word RAM model.
module tb_ram_block_copier;
  logic        clock;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [11:0] start_src;
  logic [11:0] start_dst;
  logic [10:0] start_len;
  logic        start_fill;
  logic [31:0] start_pattern;
  logic [11:0] mem_addr;
  logic        mem_cs;
  logic        mem_wren;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [10:0] words_done;

  logic [31:0] ram [0:1023];
  logic        load_en;
  logic [9:0]  load_idx;
  logic [31:0] load_data;

  int errors = 0;
  int checks = 0;

  ram_block_copier #(.ADDR_WIDTH(12), .LEN_WIDTH(11)) dut (
    .clock(clock), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_src(start_src), .start_dst(start_dst), .start_len(start_len),
`ifdef COPY_FILL_EN
    .start_fill(start_fill), .start_pattern(start_pattern),
`endif
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_wren(mem_wren),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .words_done(words_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // RAM model: byte-masked writes, registered reads, plus a bench preload path.
  always @(posedge clock) begin
    if (load_en) begin
      ram[load_idx] <= load_data;
    end else if (mem_cs && mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else if (mem_cs) begin
      mem_rdata <= ram[mem_addr[11:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input logic [11:0] addr, input logic [31:0] data);
    load_en = 1'b1; load_idx = addr[11:2]; load_data = data;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // Accepts a copy, then walks the expected RD/WR sequence cycle by cycle.
  task automatic run_copy(input logic [11:0] src, input logic [11:0] dst, input logic [10:0] len);
    logic [11:0] s;
    logic [11:0] d;
    s = src & 12'hFFC;
    d = dst & 12'hFFC;
    start_src = src; start_dst = dst; start_len = len; start_fill = 1'b0;
    start_valid = 1'b1;
    @(negedge clock);
    start_valid = 1'b0;
    for (int k = 1; k <= 2 * int'(len); k++) begin
      if (k % 2 == 1) begin
        check("rd_req", {14'd0, mem_cs, mem_wren, mem_wmask, mem_addr}, {14'd0, 1'b1, 1'b0, 4'h0, s});
        check("rd_wdata", mem_wdata, 32'h0000_0000);
      end else begin
        check("wr_req", {14'd0, mem_cs, mem_wren, mem_wmask, mem_addr}, {14'd0, 1'b1, 1'b1, 4'hF, d});
        check("wr_data", mem_wdata, ram[s[11:2]]);
        check("wr_count", {21'd0, words_done}, 32'(k / 2 - 1));
        s = s + 12'd4;
        d = d + 12'd4;
      end
      if (k == 3) begin
        start_src = 12'h800; start_dst = 12'h900; start_len = 11'd0; start_valid = 1'b1;
      end
      if (k == 4) start_valid = 1'b0;
      @(negedge clock);
    end
    check("done_pulse", {28'd0, done, busy, start_ready, mem_cs}, {28'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    @(negedge clock);
    check("idle_again", {28'd0, done, busy, start_ready, mem_cs}, {28'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    check("words_done", {21'd0, words_done}, {21'd0, len});
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; start_src = 12'd0; start_dst = 12'd0;
    start_len = 11'd0; start_fill = 1'b0; start_pattern = 32'd0;
    load_en = 1'b0; load_idx = 10'd0; load_data = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_status", {28'd0, done, busy, start_ready, mem_cs}, {28'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    check("rst_mem", {mem_wren, mem_wmask, mem_addr}, 17'd0);
    check("rst_words", {21'd0, words_done}, 32'd0);
    reset = 1'b0;

    load(12'h100, 32'h1111_1111); load(12'h104, 32'h2222_2222);
    load(12'h108, 32'h3333_3333); load(12'h10C, 32'h4444_4444);
    load(12'h000, 32'hA0A0_A0A0); load(12'h004, 32'hB0B0_B0B0);
    for (int i = 0; i < 8; i++) begin
      load(12'h300 + 12'(4 * i), 32'h3000_0000 + 32'(i));
      load(12'h380 + 12'(4 * i), 32'hEEEE_0000 + 32'(i));
    end

    run_copy(12'h100, 12'h200, 11'd4);
    check("dst_200", ram[10'h080], 32'h1111_1111);
    check("dst_204", ram[10'h081], 32'h2222_2222);
    check("dst_208", ram[10'h082], 32'h3333_3333);
    check("dst_20C", ram[10'h083], 32'h4444_4444);

    run_copy(12'h100, 12'h200, 11'd0);

    run_copy(12'h103, 12'h206, 11'd1);
    check("unaligned", ram[10'h081], 32'h1111_1111);

    run_copy(12'h000, 12'hFFC, 11'd2);
    check("wrap_FFC", ram[10'h3FF], 32'hA0A0_A0A0);
    check("wrap_000", ram[10'h000], 32'hB0B0_B0B0);

    // Reset lands on the third write of an 8-word copy.
    start_src = 12'h300; start_dst = 12'h380; start_len = 11'd8; start_valid = 1'b1;
    @(negedge clock);
    start_valid = 1'b0;
    repeat (5) @(negedge clock);
    check("third_wr", {14'd0, mem_cs, mem_wren, mem_wmask, mem_addr}, {14'd0, 1'b1, 1'b1, 4'hF, 12'h388});
    reset = 1'b1;
    #1;
    check("rst_gate", {15'd0, mem_cs, mem_wren, mem_wmask, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(negedge clock);
    check("rst_idle", {28'd0, done, busy, start_ready, mem_cs}, {28'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    check("rst_count", {21'd0, words_done}, 32'd0);
    reset = 1'b0;
    check("rst_w0", ram[10'h0E0], 32'h3000_0000);
    check("rst_w1", ram[10'h0E1], 32'h3000_0001);
    check("rst_w2", ram[10'h0E2], 32'hEEEE_0002);

`ifdef COPY_FILL_EN
    start_dst = 12'h040; start_len = 11'd3; start_fill = 1'b1;
    start_pattern = 32'hDEAD_BEEF; start_valid = 1'b1;
    @(negedge clock);
    start_valid = 1'b0; start_fill = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("fill_req", {14'd0, mem_cs, mem_wren, mem_wmask, mem_addr},
            {14'd0, 1'b1, 1'b1, 4'hF, 12'h040 + 12'(4 * k)});
      check("fill_data", mem_wdata, 32'hDEAD_BEEF);
      @(negedge clock);
    end
    check("fill_done", {31'd0, done}, 32'd1);
    @(negedge clock);
    check("fill_words", {21'd0, words_done}, 32'd3);
    check("fill_ram", ram[10'h012], 32'hDEAD_BEEF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
